// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - user-side byte handshake between i2c_slave and fabric logic.
// tx_valid exists only when CLOCK_STRETCH_EN is defined.
interface i2c_slave_if;
  logic       busy;
  logic       rw;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       stop_det;
`ifdef CLOCK_STRETCH_EN
  logic       tx_valid;

  modport slave (output busy, rw, rx_data, rx_valid, tx_req, stop_det,
                 input  tx_data, tx_valid);
  modport master (input  busy, rw, rx_data, rx_valid, tx_req, stop_det,
                  output tx_data, tx_valid);
`else
  modport slave (output busy, rw, rx_data, rx_valid, tx_req, stop_det,
                 input  tx_data);
  modport master (input  busy, rw, rx_data, rx_valid, tx_req, stop_det,
                  output tx_data);
`endif
endinterface

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target: filtered START/STOP detect, 7-bit address match, byte rx/tx.
// Define CLOCK_STRETCH_EN to add scl stretching and the tx_valid input.
module i2c_slave #(
  parameter logic [6:0] ADDR       = 7'h42,
  parameter int         FILTER_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire          scl,
  inout  wire          sda,
  i2c_slave_if.slave   bus
);
  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  // index 0 = scl, index 1 = sda
  logic [1:0]    s1, s2, filt, prev;
  logic [CW-1:0] cnt [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 2'b11;
      s2     <= 2'b11;
      filt   <= 2'b11;
      prev   <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1   <= {sda, scl};
      s2   <= s1;
      prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise =  filt[0] & ~prev[0];
  assign scl_fall = ~filt[0] &  prev[0];
  assign start_c  = ~filt[1] &  prev[1] & filt[0] & prev[0];
  assign stop_c   =  filt[1] & ~prev[1] & filt[0] & prev[0];

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n, rx_data_r, rx_data_n;
  logic       sda_oe, sda_oe_n, rw_r, rw_n, busy_r, busy_n;
  logic       rx_valid_r, rx_valid_n, tx_req_r, tx_req_n, stop_det_r, stop_det_n;
  logic       byte_done, byte_done_n, load_pend, load_pend_n, load_now;
`ifdef CLOCK_STRETCH_EN
  logic       scl_oe, scl_oe_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd7;
      shift      <= 8'h00;
      rx_data_r  <= 8'h00;
      sda_oe     <= 1'b0;
      rw_r       <= 1'b0;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      stop_det_r <= 1'b0;
      byte_done  <= 1'b0;
      load_pend  <= 1'b0;
`ifdef CLOCK_STRETCH_EN
      scl_oe     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      rx_data_r  <= rx_data_n;
      sda_oe     <= sda_oe_n;
      rw_r       <= rw_n;
      busy_r     <= busy_n;
      rx_valid_r <= rx_valid_n;
      tx_req_r   <= tx_req_n;
      stop_det_r <= stop_det_n;
      byte_done  <= byte_done_n;
      load_pend  <= load_pend_n;
`ifdef CLOCK_STRETCH_EN
      scl_oe     <= scl_oe_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rx_data_n   = rx_data_r;
    sda_oe_n    = sda_oe;
    rw_n        = rw_r;
    busy_n      = busy_r;
    rx_valid_n  = 1'b0;
    tx_req_n    = 1'b0;
    stop_det_n  = 1'b0;
    byte_done_n = byte_done;
    load_pend_n = load_pend;
    load_now    = 1'b0;
`ifdef CLOCK_STRETCH_EN
    scl_oe_n    = scl_oe;
`endif
    if (stop_c || start_c) begin
      state_n     = stop_c ? IDLE : ADDR_S;
      stop_det_n  = stop_c;
      bit_cnt_n   = 3'd7;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      byte_done_n = 1'b0;
      load_pend_n = 1'b0;
`ifdef CLOCK_STRETCH_EN
      scl_oe_n    = 1'b0;
`endif
    end else begin
      case (state)
        ADDR_S: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_f};
            if (bit_cnt == 3'd0) begin
              if (shift[6:0] == ADDR) begin
                rw_n        = sda_f;
                busy_n      = 1'b1;
                byte_done_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b1;
            state_n     = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_rise && rw_r) begin
            tx_req_n = 1'b1;
          end else if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd7;
            if (rw_r) begin
              state_n = RD_DATA;
`ifdef CLOCK_STRETCH_EN
              load_pend_n = 1'b1;
              scl_oe_n    = 1'b1;
`else
              load_now    = 1'b1;
`endif
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        WR_DATA: begin
`ifdef CLOCK_STRETCH_EN
          scl_oe_n = 1'b0;
`endif
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_f};
            if (bit_cnt == 3'd0) begin
              rx_data_n   = {shift[6:0], sda_f};
              rx_valid_n  = 1'b1;
              byte_done_n = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_n = 1'b0;
            sda_oe_n    = 1'b1;
            state_n     = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = 3'd7;
            state_n   = WR_DATA;
`ifdef CLOCK_STRETCH_EN
            scl_oe_n  = 1'b1;
`endif
          end
        end
        RD_DATA: begin
          if (load_pend) begin
`ifdef CLOCK_STRETCH_EN
            if (scl_fall) begin
              scl_oe_n = 1'b1;
            end else if (scl_oe && bus.tx_valid) begin
              load_now = 1'b1;
              scl_oe_n = 1'b0;
            end
`else
            if (scl_fall) load_now = 1'b1;
`endif
          end else if (scl_rise) begin
            if (bit_cnt == 3'd0) byte_done_n = 1'b1;
            else                 bit_cnt_n   = bit_cnt - 3'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              byte_done_n = 1'b0;
              sda_oe_n    = 1'b0;
              state_n     = RD_ACK;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              tx_req_n    = 1'b1;
              load_pend_n = 1'b1;
              state_n     = RD_DATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
    // MSB goes onto the bus in the same cycle the byte is captured
    if (load_now) begin
      shift_n     = bus.tx_data;
      sda_oe_n    = ~bus.tx_data[7];
      bit_cnt_n   = 3'd7;
      load_pend_n = 1'b0;
      byte_done_n = 1'b0;
    end
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;
`ifdef CLOCK_STRETCH_EN
  assign scl = scl_oe ? 1'b0 : 1'bz;
`endif

  assign bus.busy     = busy_r;
  assign bus.rw       = rw_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_req   = tx_req_r;
  assign bus.stop_det = stop_det_r;

  logic unused_scl_f;
  assign unused_scl_f = scl_f;
endmodule
